// File: rtl/multi_channel_accumulator_if.sv
// rtl/multi_channel_accumulator_if.sv - tagged-increment requests in, registered update reports out
interface multi_channel_accumulator_if #(
  parameter int WIDTH      = 8,
  parameter int INCR_WIDTH = 4,
  parameter int CHANNELS   = 4,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                  i_Valid;
  logic [CH_W-1:0]       i_Channel;
  logic [INCR_WIDTH-1:0] i_Incr;
  logic                  i_Clear;
  logic                  i_StickyClear;
  logic                  o_Valid;
  logic [CH_W-1:0]       o_Channel;
  logic [WIDTH-1:0]      o_Data;
  logic                  o_Overflow;
  logic [CHANNELS-1:0]   o_Sticky;

  modport master (
    output i_Valid, i_Channel, i_Incr, i_Clear, i_StickyClear,
    input  o_Valid, o_Channel, o_Data, o_Overflow, o_Sticky
  );

  modport slave (
    input  i_Valid, i_Channel, i_Incr, i_Clear, i_StickyClear,
    output o_Valid, o_Channel, o_Data, o_Overflow, o_Sticky
  );
endinterface

// File: rtl/multi_channel_accumulator.sv
// rtl/multi_channel_accumulator.sv - per-channel running sums with wrap/saturate and sticky overflow
module multi_channel_accumulator #(
  parameter int WIDTH      = 8,
  parameter int INCR_WIDTH = 4,
  parameter int CHANNELS   = 4,
  parameter int SATURATE   = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  multi_channel_accumulator_if.slave    bus
);
  localparam int             CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W:0]  NUM_CH = (CH_W + 1)'(CHANNELS);

  logic [WIDTH-1:0]    acc_q [CHANNELS];
  logic [WIDTH-1:0]    acc_d [CHANNELS];
  logic                valid_q, valid_d;
  logic [CH_W-1:0]     channel_q, channel_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                overflow_q, overflow_d;
  logic [CHANNELS-1:0] sticky_q, sticky_d;

  logic                accept;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH:0]      sum;
  logic                ovf;
  logic [WIDTH-1:0]    nxt;

  always_comb begin
    accept = bus.i_Valid && ({1'b0, bus.i_Channel} < NUM_CH);

    // Mux by comparison so an out-of-range tag never indexes past the array.
    cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.i_Channel == CH_W'(i)) cur = acc_q[i];
    end

    sum = {1'b0, cur} + (WIDTH + 1)'(bus.i_Incr);
    if (bus.i_Clear) begin
      nxt = WIDTH'(bus.i_Incr);
      ovf = 1'b0;
    end else begin
      ovf = sum[WIDTH];
      nxt = ((SATURATE != 0) && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end

    acc_d      = acc_q;
    valid_d    = accept;
    channel_d  = channel_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    sticky_d   = bus.i_StickyClear ? '0 : sticky_q;

    if (accept) begin
      channel_d  = bus.i_Channel;
      data_d     = nxt;
      overflow_d = ovf;
      // A set landing with a global clear still wins for its own channel.
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.i_Channel == CH_W'(i)) begin
          acc_d[i]    = nxt;
          sticky_d[i] = sticky_d[i] | ovf;
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      valid_q    <= 1'b0;
      channel_q  <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      sticky_q   <= '0;
    end else begin
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      channel_q  <= channel_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.o_Valid    = valid_q;
  assign bus.o_Channel  = channel_q;
  assign bus.o_Data     = data_q;
  assign bus.o_Overflow = overflow_q;
  assign bus.o_Sticky   = sticky_q;
endmodule

// File: doc/multi_channel_accumulator.md
# multi_channel_accumulator

Parametrised, multi-channel accumulator: keeps CHANNELS independent WIDTH-bit running sums, each updated by an INCR_WIDTH-bit unsigned increment tagged with a channel index. Per-update overflow detection, selectable wrap or saturate arithmetic, per-channel load/clear and sticky overflow flags. Sits between a sample/event source issuing tagged increments and downstream logic consuming a registered, valid-qualified stream of updated totals.

## Interface

Parameters:

- WIDTH, 8: accumulator width per channel, ≥ 2.
- INCR_WIDTH, 4: increment width; 1 ≤ INCR_WIDTH ≤ WIDTH.
- CHANNELS, 4: number of independent accumulators, ≥ 1.
- SATURATE, 0: 0 = wrap modulo 2^WIDTH; 1 = clamp at 2^WIDTH−1.
- CH_W (derived, not overridable): max(1, clog2(CHANNELS)).

Ports (one clock; reset is synchronous and active-high):

- i_Clock  input  1  sole clock; all state changes on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Valid  input  1  qualifies i_Channel, i_Incr and i_Clear this cycle.
- i_Channel  input  CH_W  target accumulator index.
- i_Incr  input  INCR_WIDTH  unsigned increment, zero-extended to WIDTH.
- i_Clear  input  1  with i_Valid: load the channel with i_Incr instead of adding.
- i_StickyClear  input  1  clears all sticky overflow flags.
- o_Valid  output  1  one-cycle pulse; o_Channel/o_Data/o_Overflow valid.
- o_Channel  output  CH_W  channel of the reported update.
- o_Data  output  WIDTH  new accumulator value after the update.
- o_Overflow  output  1  this update overflowed.
- o_Sticky  output  CHANNELS  per-channel sticky overflow flags.

## Operation

- Reset (i_Reset high at an edge): every accumulator, o_Valid, o_Channel, o_Data, o_Overflow and o_Sticky become 0. i_Reset has priority over every other input in that cycle.
- Accepted update: i_Valid = 1 and i_Channel < CHANNELS. Any other i_Valid cycle is dropped: no state change, o_Valid = 0 next cycle.
- Sum: S = acc[ch] + zext(i_Incr), computed at WIDTH+1 bits. Overflow = S[WIDTH].
- Wrap (SATURATE = 0): acc[ch] gets S[WIDTH−1:0].
- Saturate (SATURATE = 1): acc[ch] gets 2^WIDTH−1 on overflow, else S.
- Load (i_Clear = 1): acc[ch] gets zext(i_Incr). Overflow = 0. i_Clear with i_Incr = 0 is a plain clear.
- Unselected channels are never modified.
- Sticky flags:
  - o_Sticky[ch] is set by any accepted overflowing update.
  - i_StickyClear = 1 clears all bits.
  - If a set and i_StickyClear land in the same cycle, the set wins for that channel. All other bits clear.
- i_StickyClear acts independently of i_Valid.
- o_Channel, o_Data and o_Overflow update only on accepted updates and hold otherwise. o_Overflow is meaningful only while o_Valid = 1.

## Timing

- Latency 1: an update accepted at edge N shows o_Valid = 1 with its results after edge N. o_Valid drops after edge N+1 unless another update is accepted.
- Full throughput: one update per cycle, any channel order, no stall and no ready signal.
- Back-to-back updates to the same channel chain correctly. Cycle N+1 uses the value written at edge N, so the accumulator needs no forwarding hazard logic.
- o_Sticky reflects an overflow at the same edge as the o_Valid pulse that reports it.
- Reset mid-stream: an update presented in the reset cycle is discarded. The first post-reset update sees acc = 0.

## Test plan

Defaults unless stated: WIDTH = 8, INCR_WIDTH = 4, CHANNELS = 4, SATURATE = 0.

- Basic accumulate: reset, then ch0 +5, then ch0 +7 on consecutive cycles -> o_Data 5 then 12, o_Channel 0, o_Valid high for exactly 2 cycles, each 1 cycle after its input.
- Wrap: ch1 +15 ×17 gives 255; then ch1 +1 -> o_Data 0, o_Overflow 1, o_Sticky = 4'b0010. Same sequence with SATURATE = 1 -> o_Data 255, o_Overflow 1; a further +3 keeps 255.
- Interleave: ch2 +3, ch3 +4, ch2 +6, ch3 +1 back-to-back -> o_Data 3, 4, 9, 5. Channels 0 and 1 stay unchanged.
- Load/clear: ch0 at 12, then i_Clear with i_Incr 9 -> o_Data 9, o_Overflow 0. Overflow on ch1 in the same cycle as i_StickyClear with o_Sticky = 4'b0101 -> o_Sticky = 4'b0010.
- Reset mid-stream: ch0 at 40; raise i_Reset together with ch0 +2 -> all outputs 0 next cycle. Then ch0 +2 -> o_Data 2.
- Out-of-range channel: CHANNELS = 3, i_Valid with i_Channel 3, i_Incr 5 -> o_Valid stays 0, no accumulator or o_Sticky change, o_Data/o_Channel hold.
